// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: generic pipeline boundary register.
// Carries a payload and a valid bit between two CPU stages. The upstream and
// downstream stall bits select between load, bubble and hold. A flush input
// empties the register. Saturating counters record bubbles, holds and
// flushed entries, and a sticky flag records non-monotonic stall vectors.
module pipe_stage_reg #(
  parameter int                  DATA_W   = 64,
  parameter logic [DATA_W-1:0]   NOP_DATA = '0,
  parameter int                  STALL_W  = 6,
  parameter int                  STAGE    = 2,
  parameter int                  CNT_W    = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall,
  input  logic               flush,
  input  logic               in_valid,
  input  logic [DATA_W-1:0]  in_data,
  output logic               out_valid,
  output logic [DATA_W-1:0]  out_data,
  input  logic               clr_cnt,
  output logic [CNT_W-1:0]   bubble_cnt,
  output logic [CNT_W-1:0]   hold_cnt,
  output logic [CNT_W-1:0]   flush_cnt,
  output logic               stall_err
);

  // The downstream stall bit must exist inside the stall vector.
  if (STAGE + 1 > STALL_W - 1) begin : g_bad_stage
    $error("pipe_stage_reg: STAGE+1 (%0d) exceeds STALL_W-1 (%0d)", STAGE + 1, STALL_W - 1);
  end

  // Per-edge action chosen from flush and the two relevant stall bits.
  typedef enum logic [2:0] {
    ACT_LOAD    = 3'd0,
    ACT_BUBBLE  = 3'd1,
    ACT_HOLD    = 3'd2,
    ACT_ILLEGAL = 3'd3,
    ACT_FLUSH   = 3'd4
  } act_e;

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
    if (&cnt) begin
      return cnt;
    end
    return cnt + CNT_W'(1);
  endfunction

  logic              su;
  logic              sd;
  act_e              act;

  logic              valid_q,  valid_d;
  logic [DATA_W-1:0] data_q,   data_d;
  logic [CNT_W-1:0]  bubble_q, bubble_d;
  logic [CNT_W-1:0]  hold_q,   hold_d;
  logic [CNT_W-1:0]  flush_q,  flush_d;
  logic              err_q,    err_d;

  // Only two stall bits matter here; the rest of the vector is deliberately
  // consumed so it does not look like an oversight.
  logic unused_stall;
  assign unused_stall = ^stall;

  assign su = stall[STAGE];
  assign sd = stall[STAGE+1];

  // Classify this edge; flush outranks every stall combination.
  always_comb begin
    act = ACT_LOAD;
    if (flush) begin
      act = ACT_FLUSH;
    end else if (su && !sd) begin
      act = ACT_BUBBLE;
    end else if (su && sd) begin
      act = ACT_HOLD;
    end else if (!su && sd) begin
      act = ACT_ILLEGAL;
    end
  end

  // Next payload and valid bit; an illegal vector behaves exactly like a hold.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    unique case (act)
      ACT_FLUSH, ACT_BUBBLE: begin
        valid_d = 1'b0;
        data_d  = NOP_DATA;
      end
      ACT_HOLD, ACT_ILLEGAL: begin
        valid_d = valid_q;
        data_d  = data_q;
      end
      ACT_LOAD: begin
        valid_d = in_valid;
        data_d  = in_valid ? in_data : NOP_DATA;
      end
      default: begin
        valid_d = valid_q;
        data_d  = data_q;
      end
    endcase
  end

  // Next counter and error-flag values; a clear overrides any same-edge update.
  always_comb begin
    bubble_d = bubble_q;
    hold_d   = hold_q;
    flush_d  = flush_q;
    err_d    = err_q;
    unique case (act)
      ACT_FLUSH: begin
        if (valid_q) begin
          flush_d = sat_inc(flush_q);
        end
      end
      ACT_BUBBLE: begin
        bubble_d = sat_inc(bubble_q);
      end
      ACT_HOLD: begin
        hold_d = sat_inc(hold_q);
      end
      ACT_ILLEGAL: begin
        hold_d = sat_inc(hold_q);
        err_d  = 1'b1;
      end
      default: begin
        bubble_d = bubble_q;
      end
    endcase
    if (clr_cnt) begin
      bubble_d = '0;
      hold_d   = '0;
      flush_d  = '0;
      err_d    = 1'b0;
    end
  end

  // Payload register; reset drops any in-flight instruction to a NOP.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0;
      data_q  <= NOP_DATA;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  // Performance counters and sticky stall-error flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bubble_q <= '0;
      hold_q   <= '0;
      flush_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      bubble_q <= bubble_d;
      hold_q   <= hold_d;
      flush_q  <= flush_d;
      err_q    <= err_d;
    end
  end

  assign out_valid  = valid_q;
  assign out_data   = data_q;
  assign bubble_cnt = bubble_q;
  assign hold_cnt   = hold_q;
  assign flush_cnt  = flush_q;
  assign stall_err  = err_q;

endmodule
